// File: rtl/pipe_scoreboard.sv
// Register scoreboard and hazard unit for the in-order MIPS pipeline: tracks in-flight
// writes from issue to writeback, stalls on load-use, and registers EX forwarding selects.
module pipe_src_match #(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int SW         = 2,
    parameter int LOAD_STAGE = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic [DEPTH:1]         vld,
    input  logic [DEPTH:1][AW-1:0] dest,
    input  logic [DEPTH:1]         load,
    input  logic [AW-1:0]          src,
    input  logic                   used,
    output logic                   haz,
    output logic [SW-1:0]          fwd
);
    logic zero_src;
    assign zero_src = (ZERO_REG != 0) && (src == '0);

    // Walk oldest to youngest so the lowest matching stage has the final say.
    always_comb begin
        haz = 1'b0;
        fwd = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && !zero_src && vld[k] && dest[k] == src) begin
                haz = load[k] && (k + 1 < LOAD_STAGE);
                fwd = (k < DEPTH) ? SW'(k + 1) : '0;
            end
        end
    end
endmodule

module pipe_scoreboard #(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int SW         = 2,
    parameter int LOAD_STAGE = 3,
    parameter int ZERO_REG   = 1,
    parameter int CW         = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs,
    input  logic [AW-1:0]   iss_rt,
    input  logic            iss_rs_used,
    input  logic            iss_rt_used,
    input  logic            iss_wr,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_load,
    input  logic            flush,
    output logic            stall,
    output logic [SW-1:0]   fwd_rs,
    output logic [SW-1:0]   fwd_rt,
    output logic [NREG-1:0] pending,
    output logic [CW-1:0]   stall_cnt
);
    typedef struct packed {
        logic          vld;
        logic [AW-1:0] dest;
        logic          load;
    } ent_t;

    ent_t [DEPTH:1] pipe;

    logic [DEPTH:1]         p_vld;
    logic [DEPTH:1][AW-1:0] p_dest;
    logic [DEPTH:1]         p_load;
    logic [1:0][AW-1:0]     src;
    logic [1:0]             used;
    logic [1:0]             haz;
    logic [1:0][SW-1:0]     fwd;
    logic                   accept;
    logic                   ins;

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            p_vld[k]  = pipe[k].vld;
            p_dest[k] = pipe[k].dest;
            p_load[k] = pipe[k].load;
        end
    end

    assign src  = {iss_rt, iss_rs};
    assign used = {iss_rt_used, iss_rs_used};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_src
            pipe_src_match #(
                .AW(AW), .DEPTH(DEPTH), .SW(SW),
                .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)
            ) u_match (
                .vld(p_vld), .dest(p_dest), .load(p_load),
                .src(src[g]), .used(used[g]),
                .haz(haz[g]), .fwd(fwd[g])
            );
        end
    endgenerate

    assign stall  = iss_valid && !flush && (|haz);
    assign accept = iss_valid && !stall && !flush;
    assign ins    = accept && iss_wr && !((ZERO_REG != 0) && iss_rd == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pipe      <= '0;
            fwd_rs    <= '0;
            fwd_rt    <= '0;
            stall_cnt <= '0;
        end else begin
            pipe[1] <= ins ? ent_t'{vld: 1'b1, dest: iss_rd, load: iss_load} : '0;
            // A flush squashes the instruction currently in EX as it moves on.
            for (int k = 2; k <= DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
                if (k == 2 && flush) pipe[k].vld <= 1'b0;
            end
            fwd_rs <= accept ? fwd[0] : '0;
            fwd_rt <= accept ? fwd[1] : '0;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 1; k <= DEPTH; k++)
            if (pipe[k].vld) pending[pipe[k].dest] = 1'b1;
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench for pipe_scoreboard: directed hazard scenarios then random traffic,
// checked against an instruction-list model of the in-flight writes.
module tb_pipe_scoreboard;
    localparam int NREG = 32, AW = 5, DEPTH = 3, SW = 2, LS = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            iss_valid = 1'b0, iss_rs_used = 1'b0, iss_rt_used = 1'b0;
    logic            iss_wr = 1'b0, iss_load = 1'b0, flush = 1'b0;
    logic [AW-1:0]   iss_rs = '0, iss_rt = '0, iss_rd = '0;
    logic            stall, stall2;
    logic [SW-1:0]   fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
    logic [NREG-1:0] pending, pending2;
    logic [15:0]     stall_cnt;
    logic [1:0]      stall_cnt2;

    always #5 clock = ~clock;

    pipe_scoreboard #(.CW(16)) u_dut (
        .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used), .iss_wr(iss_wr), .iss_rd(iss_rd),
        .iss_load(iss_load), .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .pending(pending), .stall_cnt(stall_cnt)
    );

    pipe_scoreboard #(.CW(2)) u_dut2 (
        .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used), .iss_wr(iss_wr), .iss_rd(iss_rd),
        .iss_load(iss_load), .flush(flush), .stall(stall2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2),
        .pending(pending2), .stall_cnt(stall_cnt2)
    );

    typedef struct { int dest; bit load; int cyc; } inf_t;
    typedef struct { bit stall; logic [31:0] pend; int frs, frt, cnt, cnt2; } exp_t;

    inf_t inflight[$];
    exp_t expq[$];
    int   errors = 0, checks = 0;
    int   now = 0;
    int   m_frs = 0, m_frt = 0, m_cnt = 0, m_cnt2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Age of the youngest in-flight writer of s (0 when none) and whether it is a load.
    function automatic int youngest(input int s, input bit u, output bit ld);
        int best = -1;
        ld = 1'b0;
        if (!u || s == 0) return 0;
        foreach (inflight[i])
            if (inflight[i].dest == s && inflight[i].cyc > best) begin
                best = inflight[i].cyc;
                ld   = inflight[i].load;
            end
        return (best < 0) ? 0 : now - best;
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                        input bit wr, input int rd, input bit ld, input bit fl, input bit rst);
        int   ks, kt;
        bit   ls, lt, st, acc;
        exp_t e;
        @(posedge clock);
        #1;
        iss_valid = v; iss_rs = AW'(rs); iss_rt = AW'(rt); iss_rs_used = ru; iss_rt_used = tu;
        iss_wr = wr; iss_rd = AW'(rd); iss_load = ld; flush = fl; reset = rst;
        now++;
        for (int i = inflight.size() - 1; i >= 0; i--)
            if (now - inflight[i].cyc > DEPTH) inflight.delete(i);
        ks = youngest(rs, ru, ls);
        kt = youngest(rt, tu, lt);
        st = v && !fl && ((ks > 0 && ls && ks + 1 < LS) || (kt > 0 && lt && kt + 1 < LS));
        e.stall = st;
        e.pend  = '0;
        foreach (inflight[i]) e.pend[inflight[i].dest] = 1'b1;
        e.frs = m_frs; e.frt = m_frt; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        expq.push_back(e);
        acc = v && !st && !fl;
        if (!rst) begin
            inflight.delete();
            m_frs = 0; m_frt = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_frs = (acc && ks > 0 && ks < DEPTH) ? ks + 1 : 0;
            m_frt = (acc && kt > 0 && kt < DEPTH) ? kt + 1 : 0;
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (fl)
                for (int i = inflight.size() - 1; i >= 0; i--)
                    if (inflight[i].cyc == now - 1) inflight.delete(i);
            if (acc && wr && rd != 0) inflight.push_back('{rd, ld, now});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("stall_w2", 32'(stall2), 32'(e.stall));
                chk("pending", pending, e.pend);
                chk("fwd_rs", 32'(fwd_rs), e.frs);
                chk("fwd_rt", 32'(fwd_rt), e.frt);
                chk("stall_cnt", 32'(stall_cnt), e.cnt);
                chk("stall_cnt_w2", 32'(stall_cnt2), e.cnt2);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // add $3,$1,$2 ; sub $4,$3,$1
        step(1, 1, 2, 1, 1, 1, 3, 0, 0, 1);
        step(1, 3, 1, 1, 1, 1, 4, 0, 0, 1);
        idle(4);
        // lw $5 ; add $6,$5,$5 (stalls once, then retried)
        step(1, 1, 0, 1, 0, 1, 5, 1, 0, 1);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0, 1);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0, 1);
        idle(4);
        // addi $7,$0,5 ; two unrelated ; add $8,$7,$0
        step(1, 0, 0, 1, 0, 1, 7, 0, 0, 1);
        step(1, 11, 12, 1, 1, 1, 10, 0, 0, 1);
        step(1, 11, 12, 1, 1, 1, 10, 0, 0, 1);
        step(1, 7, 0, 1, 1, 1, 8, 0, 0, 1);
        idle(4);
        // write $0 then read $0
        step(1, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1, 9, 0, 0, 1);
        idle(4);
        // add $9 squashed by flush ; dependent add
        step(1, 1, 2, 1, 1, 1, 9, 0, 1, 1);
        step(1, 9, 9, 1, 1, 1, 10, 0, 0, 1);
        idle(4);
        // five load-use stalls saturate the narrow counter
        repeat (5) begin
            step(1, 1, 0, 1, 0, 1, 5, 1, 0, 1);
            step(1, 2, 5, 1, 1, 1, 6, 0, 0, 1);
            step(1, 2, 5, 1, 1, 1, 6, 0, 0, 1);
        end
        @(negedge clock);
        chk("cnt2_saturated", 32'(stall_cnt2), 32'd3);
        // reset asserted while a load-use stall is active
        step(1, 1, 0, 1, 0, 1, 5, 1, 0, 1);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0, 0);
        idle(3);
        repeat (400) begin
            step(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom % 2, $urandom % 2, ($urandom % 4) != 0, $urandom_range(0, 7),
                 ($urandom % 3) == 0, ($urandom % 16) == 0, ($urandom % 64) != 0);
        end
        idle(4);
        repeat (3) @(negedge clock);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised register scoreboard and hazard unit for the in-order MIPS pipeline.
- It tracks every in-flight register write from issue (decode→EX) through writeback and produces an issue stall for load-use hazards.
- For each source operand it produces a registered forwarding select, aligned with EX, that replaces the hard-wired 2-bit per-register table.
- Depth, register count and load latency are generalised; it adds flush, a zero register, a pending vector and a saturating stall counter.

Parameters:
- NREG, 32: number of architectural registers.
- AW, 5: register index width, equal to clog2(NREG).
- DEPTH, 3: in-flight stages after issue. Stage 1 is EX and stage DEPTH is WB.
- SW, 2: forwarding select width, equal to clog2(DEPTH+1).
- LOAD_STAGE, 3: first stage whose output holds load data.
- ZERO_REG, 1: when 1, register 0 is never tracked.
- CW, 16: stall counter width.

Ports:
- clock, in, 1: pipeline clock.
- reset, in, 1: synchronous reset, active-low.
- iss_valid, in, 1: a decode-stage instruction is presented.
- iss_rs, in, AW: first source register.
- iss_rt, in, AW: second source register.
- iss_rs_used, in, 1: the instruction reads rs.
- iss_rt_used, in, 1: the instruction reads rt.
- iss_wr, in, 1: the instruction writes a register.
- iss_rd, in, AW: destination register.
- iss_load, in, 1: the instruction is a load.
- flush, in, 1: branch or jump taken in EX.
- stall, out, 1: combinational; hold PC and decode this cycle.
- fwd_rs, out, SW: registered; EX operand-A source.
- fwd_rt, out, SW: registered; EX operand-B source.
- pending, out, NREG: bit r is set when a valid in-flight entry targets r.
- stall_cnt, out, CW: saturating count of stall cycles.

Behaviour:
- State is a shift pipeline of DEPTH entries. Each entry holds {valid, dest[AW], load}. It advances one stage every clock with no back-pressure, and the entry in stage DEPTH retires.
- Insertion into stage 1:
  - A new entry {1, iss_rd, iss_load} is inserted only when iss_valid=1, iss_wr=1, stall=0 and flush=0.
  - When ZERO_REG=1, iss_rd=0 is not inserted.
  - In every other case stage 1 receives a bubble (valid=0).
- Match rule, per used source s:
  - k is the lowest-numbered stage holding a valid entry with dest==s.
  - The youngest producer wins, so multiple matches resolve to the lowest k.
  - Register 0 never matches when ZERO_REG=1.
- stall is 1 when iss_valid=1, flush=0, and some used source matches at a stage k whose entry has load=1 and k+1 < LOAD_STAGE. Otherwise stall is 0.
- Forwarding select, next value, for an accepted issue (iss_valid=1, stall=0, flush=0):
  - No match: 0, meaning read the register file.
  - Match at k=DEPTH: 0. The write completes this edge and the register file read is valid next cycle.
  - Match at k<DEPTH: k+1, meaning use the output register of stage k+1 while the consumer is in EX.
  - A source with used=0 gives 0.
- Otherwise fwd_rs and fwd_rt load 0.
- pending is the OR over valid entries of one-hot(dest). It is combinational from the current state.
- stall_cnt increments by 1 on each clock where stall=1, and saturates at 2^CW-1.
- flush:
  - Invalidates the stage-1 entry (the instruction being squashed) at this edge while it shifts.
  - Drops the current issue and forces stall=0.
  - Loads 0 into fwd_rs and fwd_rt.
  - Stages 2..DEPTH are unaffected.
- Simultaneous issue and retirement of the same register: the new entry is inserted and pending[r] stays 1.
- Reset (reset=0 at a clock edge): all entries go invalid, fwd_rs=fwd_rt=0, stall_cnt=0 and pending=0. Reset takes priority over flush and issue, including mid-stream. The first issue after reset sees no hazards.
- Latency: stall is same-cycle. fwd_rs and fwd_rt are valid one cycle after acceptance.

Test Plan:
- Reset, then issue add $3,$1,$2 followed by sub $4,$3,$1 → stall=0. Second issue gives fwd_rs=2 and fwd_rt=0. pending[3]=1 for 3 cycles, then 0.
- lw $5,0($1) followed by add $6,$5,$5 → stall=1 for exactly 1 cycle and stall_cnt=1. On the retry, fwd_rs=fwd_rt=3.
- addi $7,$0,5 followed by two unrelated instructions, then add $8,$7,$0 → fwd_rs=0 (retired via WB), fwd_rt=0, and pending[7] is clear by the consumer's EX cycle.
- Write to $0 followed by a read of $0 → nothing is inserted, pending=0, fwd=0 and stall=0.
- Issue add $9,... with flush=1 in the same cycle → no entry is inserted and fwd=0. A dependent add next cycle gets fwd=0 and stall=0.
- Hold the load-use condition with CW=2 for 5 cycles → stall_cnt=3 (saturated). reset=0 mid-stall → all outputs 0 on the next edge.
